// File: rtl/conv_window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen_pkg
//  Purpose  : Shared sizing helpers and constants for the convolution window
//             generator and the MAC stage that consumes its windows.
//  Revision : 1.0  initial release
// ============================================================================
package conv_window_gen_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Width of a counter spanning 0..count-1; never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count <= 1) ? 1 : clog2(count);
    endfunction

    // Width of one flattened KERNEL x KERNEL window of N-bit pixels.
    function automatic int win_width(input int kernel, input int n);
        return kernel * kernel * n;
    endfunction

    // Default geometry shared with the MAC stage.
    localparam int c_KERNEL = 3;
    localparam int c_N      = 8;
    localparam int c_IMG_W  = 28;
    localparam int c_IMG_H  = 28;
    localparam int c_COL_W  = cnt_width(c_IMG_W);
    localparam int c_ROW_W  = cnt_width(c_IMG_H);
    localparam int c_WIN_W  = win_width(c_KERNEL, c_N);

endpackage
`default_nettype wire

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen_if
//  Purpose  : Pixel-stream input and window output bundle of the convolution
//             window generator. master = stream source, slave = generator.
//  Revision : 1.0  initial release
// ============================================================================
interface conv_window_gen_if
    import conv_window_gen_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 8
);
    logic [N-1:0]                      pix_in;
    logic                              en_in;
    logic                              sof;
    logic [win_width(KERNEL, N)-1:0]   data2conv;
    logic                              en_out;
    logic                              last_out;

    modport master (
        output pix_in, en_in, sof,
        input  data2conv, en_out, last_out
    );

    modport slave (
        input  pix_in, en_in, sof,
        output data2conv, en_out, last_out
    );
endinterface
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_line_buffer
//  Purpose  : One image-row delay: a circular RAM of DEPTH words read and
//             written at the same pointer, so dout is the word written DEPTH
//             enabled cycles earlier. Storage is deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);
    localparam int                c_PTR_W    = cnt_width(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;

    // Read-before-write at the shared pointer gives exactly one row of delay.
    assign dout = r_mem[r_ptr];

    // Pointer walks the RAM once per accepted pixel and wraps at DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Overwrite the slot just read with the incoming pixel.
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end
endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Turns a raster pixel stream into fully-populated KERNEL x KERNEL
//             windows for the MAC stage. KERNEL-1 line buffers supply the rows
//             above; row/col counters gate out partial windows.
//  Revision : 1.0  initial release
// ============================================================================
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int KERNEL = 3,
    parameter int N      = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv_window_gen_if.slave bus
);
    localparam int                 c_COL_W    = cnt_width(IMG_W);
    localparam int                 c_ROW_W    = cnt_width(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_EDGE = c_COL_W'(KERNEL - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_EDGE = c_ROW_W'(KERNEL - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_take_sof;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_full;
    logic               r_en_out;
    logic               r_last_out;
    logic [N-1:0]       w_chain [KERNEL];
    logic [N-1:0]       r_win   [KERNEL*KERNEL];

    // Position of the pixel being accepted now; sof forces it to (0,0).
    assign w_take_sof = bus.en_in & bus.sof;
    assign w_col      = w_take_sof ? '0 : r_col;
    assign w_row      = w_take_sof ? '0 : r_row;
    assign w_col_last = (w_col == c_COL_LAST);
    assign w_row_last = (w_row == c_ROW_LAST);
    assign w_full     = (w_row >= c_ROW_EDGE) && (w_col >= c_COL_EDGE);

    // Raster position counters; they wrap at end of row and end of frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (bus.en_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Cascade of row delays: w_chain[j] holds the pixel j rows above pix_in.
    assign w_chain[0] = bus.pix_in;

    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_lbuf
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (N)
        ) u_lbuf (
            .clk  (clk),
            .rst  (rst),
            .en   (bus.en_in),
            .din  (w_chain[j]),
            .dout (w_chain[j+1])
        );
    end

    // Window shifts left one column per accepted pixel; the new right column
    // is the vertical slice ending at pix_in (bottom row = newest pixel).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KERNEL * KERNEL; i++) begin
                r_win[i] <= '0;
            end
        end else if (bus.en_in) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 1; c++) begin
                    r_win[r*KERNEL + c] <= r_win[r*KERNEL + c + 1];
                end
                r_win[r*KERNEL + KERNEL - 1] <= w_chain[KERNEL - 1 - r];
            end
        end
    end

    // Output strobes: valid only for complete windows, last at frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_out   <= 1'b0;
            r_last_out <= 1'b0;
        end else begin
            r_en_out   <= bus.en_in & w_full;
            r_last_out <= bus.en_in & w_row_last & w_col_last;
        end
    end

    for (genvar i = 0; i < KERNEL * KERNEL; i++) begin : g_flat
        assign bus.data2conv[i*N +: N] = r_win[i];
    end

    assign bus.en_out   = r_en_out;
    assign bus.last_out = r_last_out;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_gen
//  Purpose  : Self-checking bench for conv_window_gen (KERNEL=3, 5x5 image)
//             with a KERNEL=1 instance driven by the same stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_window_gen;
    localparam int c_K  = 3;
    localparam int c_N  = 8;
    localparam int c_W  = 5;
    localparam int c_H  = 5;
    localparam int c_WW = c_K * c_K * c_N;

    logic clk;
    logic rst;

    conv_window_gen_if #(.KERNEL(c_K), .N(c_N)) bus  ();
    conv_window_gen_if #(.KERNEL(1),   .N(c_N)) bus1 ();

    conv_window_gen #(.KERNEL(c_K), .N(c_N), .IMG_W(c_W), .IMG_H(c_H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_window_gen #(.KERNEL(1), .N(c_N), .IMG_W(c_W), .IMG_H(c_H)) dut_k1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [c_WW-1:0] sb_q [$];
    int              m_row, m_col;
    int              img [c_H][c_W];
    logic            exp_en, exp_last;
    logic            k1_exp_en;
    logic [c_N-1:0]  k1_exp_data;

    // Observation helpers
    int              n_win, n_last;
    logic            arm_first;
    logic [c_WW-1:0] first_win, last_win;

    task automatic check(input string tag, input logic [c_WW-1:0] got, input logic [c_WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected window whose top-left pixel has value b in a raster-valued frame.
    function automatic logic [c_WW-1:0] win_at(input int b);
        logic [c_WW-1:0] w;
        for (int i = 0; i < c_K * c_K; i++) begin
            w[i*c_N +: c_N] = 8'(b + (i / c_K) * c_W + (i % c_K));
        end
        return w;
    endfunction

    // Compare DUT outputs produced by the previous drive.
    task automatic sample();
        logic [c_WW-1:0] exp_w;
        check("en_out", c_WW'(bus.en_out), c_WW'(exp_en));
        check("last_out", c_WW'(bus.last_out), c_WW'(exp_last));
        if (bus.en_out) begin
            n_win++;
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                check("window", bus.data2conv, exp_w);
            end else begin
                check("sb_underflow", c_WW'(sb_q.size()), c_WW'(1));
            end
            if (arm_first) begin
                first_win = bus.data2conv;
                arm_first = 1'b0;
            end
            if (bus.last_out) begin
                last_win = bus.data2conv;
                n_last++;
            end
        end
        check("k1_en_out", c_WW'(bus1.en_out), c_WW'(k1_exp_en));
        check("k1_data", c_WW'(bus1.data2conv), c_WW'(k1_exp_data));
    endtask

    task automatic drive(input logic en, input logic s, input logic [c_N-1:0] pix);
        logic [c_WW-1:0] w;
        @(negedge clk);
        sample();
        bus.en_in  = en;   bus.sof  = s;  bus.pix_in  = pix;
        bus1.en_in = en;   bus1.sof = s;  bus1.pix_in = pix;
        exp_en    = 1'b0;
        exp_last  = 1'b0;
        k1_exp_en = en;
        if (en) begin
            k1_exp_data = pix;
            if (s) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = int'(pix);
            if (m_row >= c_K - 1 && m_col >= c_K - 1) begin
                for (int r = 0; r < c_K; r++)
                    for (int c = 0; c < c_K; c++)
                        w[(r*c_K + c)*c_N +: c_N] = 8'(img[m_row-c_K+1+r][m_col-c_K+1+c]);
                sb_q.push_back(w);
                exp_en = 1'b1;
            end
            exp_last = (m_row == c_H - 1) && (m_col == c_W - 1);
            if (m_col == c_W - 1) begin
                m_col = 0;
                m_row = (m_row == c_H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    endtask

    // Pulse reset for one cycle mid-stream; outputs must clear at once.
    task automatic pulse_reset();
        @(negedge clk);
        sample();
        bus.en_in = 1'b0;  bus.sof = 1'b0;
        bus1.en_in = 1'b0; bus1.sof = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_data", bus.data2conv, '0);
        check("rst_en", c_WW'(bus.en_out), '0);
        check("rst_last", c_WW'(bus.last_out), '0);
        check("rst_k1_data", c_WW'(bus1.data2conv), '0);
        m_row = 0; m_col = 0;
        sb_q.delete();
        exp_en = 1'b0; exp_last = 1'b0;
        k1_exp_en = 1'b0; k1_exp_data = '0;
        @(negedge clk);
        sample();
        rst = 1'b1;
    endtask

    task automatic frame(input int offset, input int npix, input logic with_sof);
        for (int p = 0; p < npix; p++) begin
            drive(1'b1, with_sof && (p == 0), 8'(offset + p + 1));
        end
    endtask

    initial begin
        int n0, l0, p;
        rst = 1'b1;
        bus.en_in = 1'b0;  bus.sof = 1'b0;  bus.pix_in = '0;
        bus1.en_in = 1'b0; bus1.sof = 1'b0; bus1.pix_in = '0;
        m_row = 0; m_col = 0;
        exp_en = 1'b0; exp_last = 1'b0;
        k1_exp_en = 1'b0; k1_exp_data = '0;
        n_win = 0; n_last = 0; arm_first = 1'b0;
        first_win = '0; last_win = '0;
        #2 rst = 1'b0;
        #2;
        check("init_data", bus.data2conv, '0);
        check("init_en", c_WW'(bus.en_out), '0);
        check("init_last", c_WW'(bus.last_out), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Continuous frame with sof: first/last windows and window count.
        n0 = n_win; l0 = n_last; arm_first = 1'b1;
        frame(0, 25, 1'b1);
        drive(1'b0, 1'b0, 8'h00);
        check("s1_first", first_win, win_at(1));
        check("s1_last", last_win, win_at(13));
        check("s1_count", c_WW'(n_win - n0), c_WW'(9));
        check("s1_nlast", c_WW'(n_last - l0), c_WW'(1));

        // Random gaps; sof and pixel noise while en_in is low must be ignored.
        n0 = n_win; arm_first = 1'b1; p = 0;
        while (p < 25) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, p == 0, 8'(p + 1));
                p++;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        check("s3_first", first_win, win_at(1));
        check("s3_last", last_win, win_at(13));
        check("s3_count", c_WW'(n_win - n0), c_WW'(9));

        // Back-to-back frames; second one relies on counter wrap, no sof.
        n0 = n_win;
        frame(0, 25, 1'b1);
        drive(1'b1, 1'b0, 8'(101));
        arm_first = 1'b1;
        for (int q = 1; q < 25; q++) drive(1'b1, 1'b0, 8'(100 + q + 1));
        drive(1'b0, 1'b0, 8'h00);
        check("s4_first", first_win, win_at(101));
        check("s4_last", last_win, win_at(113));
        check("s4_count", c_WW'(n_win - n0), c_WW'(18));

        // Frame aborted at pixel 8 by a new sof.
        n0 = n_win;
        frame(0, 7, 1'b1);
        arm_first = 1'b1;
        frame(70, 25, 1'b1);
        drive(1'b0, 1'b0, 8'h00);
        check("s5_first", first_win, win_at(71));
        check("s5_count", c_WW'(n_win - n0), c_WW'(9));

        // Reset mid-frame, restart without sof.
        frame(0, 12, 1'b1);
        pulse_reset();
        n0 = n_win; arm_first = 1'b1;
        frame(150, 25, 1'b0);
        drive(1'b0, 1'b0, 8'h00);
        check("s6_first", first_win, win_at(151));
        check("s6_last", last_win, win_at(163));
        check("s6_count", c_WW'(n_win - n0), c_WW'(9));

        repeat (2) drive(1'b0, 1'b0, 8'h00);
        check("sb_leftover", c_WW'(sb_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Upstream feeder for the convolution MAC stage. Accepts a raster-order pixel stream, one pixel per enabled cycle, and buffers KERNEL-1 image rows in line buffers. It emits a flattened KERNEL x KERNEL window on data2conv with en_out, in the packing the MAC stage expects. Only fully-populated windows are emitted (valid convolution, no padding).

Parameters:
KERNEL, 3, window size; legal values 1/3/5/7
N, 8, pixel width in bits (signed two's complement, passed through unmodified)
IMG_W, 28, image width in pixels; must be >= KERNEL
IMG_H, 28, image height in pixels; must be >= KERNEL

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
pix_in  in  N  input pixel
en_in  in  1  pix_in valid this cycle
sof  in  1  qualified by en_in; the pixel is row 0, col 0 of a new frame
data2conv  out  KERNEL*KERNEL*N  window; element i = r*KERNEL+c at bits [i*N +: N]
en_out  out  1  data2conv valid this cycle
last_out  out  1  with en_out: window ends at pixel (IMG_H-1, IMG_W-1)

Behaviour:
- Single clock. Asynchronous active-low reset: rst=0 clears data2conv, en_out, last_out, row/col counters and window registers to 0 immediately. Line-buffer storage is not reset.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on en_in=1.
  - col wraps to 0 and row increments at IMG_W-1.
  - At (IMG_H-1, IMG_W-1), both wrap to 0. Frames run back-to-back with no gap.
- sof=1 with en_in=1: the accepted pixel is taken as (0,0), whatever the counter state. Counters then continue from (0,1). sof without en_in is ignored.
- Line buffers: KERNEL-1 cascaded row delays, each IMG_W deep. A buffer advances only on en_in=1. Buffer j output is the pixel from j+1 rows above at the same column.
- Window: KERNEL x KERNEL shift register, shifted left by one column per accepted pixel.
  - The new right column is {buffer KERNEL-2 output, ..., buffer 0 output, pix_in}, top to bottom.
  - Row r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- Latency: 1 cycle. In the cycle after a pixel is accepted at (row, col):
  - en_out=1 iff row >= KERNEL-1 and col >= KERNEL-1.
  - Element (r, c) = pixel (row-KERNEL+1+r, col-KERNEL+1+c).
  - last_out=1 iff row=IMG_H-1 and col=IMG_W-1; otherwise 0.
- en_in=0: nothing advances. en_out=0 and last_out=0 next cycle. data2conv holds its last value.
- Stale columns from the previous row, and line-buffer contents after sof or reset, are never exposed: the row/col gating masks them.
- Windows per frame: (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1).
- KERNEL=1: no line buffers. data2conv = pix_in registered, en_out = en_in delayed one cycle.
- Reset mid-frame: the next accepted pixel is (0,0), regardless of sof.

Decomposition:
- Shared package:
  - clog2 function
  - counter widths for IMG_W and IMG_H
  - window width constant KERNEL*KERNEL*N, also used by the MAC stage
- Sub-module conv_line_buffer: one row delay of depth IMG_W, width N, enable-gated, implemented as a circular RAM with a pointer. It is instantiated KERNEL-1 times via generate.

Test Plan:
All scenarios use KERNEL=3, IMG_W=5, IMG_H=5 and pixel value row*5+col+1 (1..25) unless stated.
1. Continuous en_in, sof on pixel 1 -> first en_out the cycle after pixel 13. Window i=0..8 = 1,2,3,6,7,8,11,12,13. Exactly 9 en_out pulses per frame.
2. Same frame -> last window = 13,14,15,18,19,20,23,24,25 with last_out=1. last_out=0 on the other 8 windows.
3. Random en_in gaps (~50% duty) -> identical window sequence to scenario 1. en_out never asserted in a cycle following en_in=0.
4. Two back-to-back frames, second frame pixel value +100 -> second frame's first window = 101,102,103,106,107,108,111,112,113. No window mixes frames.
5. sof asserted at old-frame pixel 8, followed by a fresh frame -> no en_out until new pixel 13. Windows then contain only new-frame data.
6. rst low for 1 cycle mid-frame -> outputs 0 immediately. Restart without sof behaves as scenario 1. KERNEL=1 build: en_out follows en_in by 1 cycle with data2conv = pix_in.
